// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem port, decode control, IF/ID register outputs
interface fetch_unit_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               flush;
  logic [PC_W-1:0]    branch_target;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [INSTR_W-1:0] if_id_imm;
  logic [PC_W-1:0]    if_id_pc;
  logic [PC_W-1:0]    if_id_pc_next;

  // fetch unit side
  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  flush,
    input  branch_target,
    output if_id_valid,
    output if_id_instr,
    output if_id_imm,
    output if_id_pc,
    output if_id_pc_next
  );

  // memory / decode side
  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output flush,
    output branch_target,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_imm,
    input  if_id_pc,
    input  if_id_pc_next
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with two-word assembly and IF/ID register
module fetch_unit #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_IMM   = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [PC_W-1:0]    ipc_next_q, ipc_next_d;

  logic [6:0]         op;
  logic               needs_imm;
  logic [PC_W-1:0]    pc_inc;

  assign op     = bus.imem_rdata[15:9];
  assign pc_inc = pc_q + PC_ONE;

  // ADDI/LDM (01x1000) and LDD/STD (101x000) carry a trailing immediate word
  assign needs_imm = ((op[6:5] == 2'b01) && (op[3:0] == 4'b1000)) ||
                     ((op[6:4] == 3'b101) && (op[2:0] == 3'b000));

  // state, PC, hold and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      imm_q        <= '0;
      ipc_q        <= '0;
      ipc_next_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      imm_q        <= imm_d;
      ipc_q        <= ipc_d;
      ipc_next_q   <= ipc_next_d;
    end
  end

  // next state: flush beats stall beats normal advance
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    ipc_d        = ipc_q;
    ipc_next_d   = ipc_next_q;

    if (bus.flush) begin
      // returning to S_FETCH drops any held opcode word
      pc_d    = bus.branch_target;
      state_d = S_FETCH;
      valid_d = 1'b0;
    end else if (!bus.stall) begin
      case (state_q)
        S_FETCH: begin
          pc_d = pc_inc;
          if (needs_imm) begin
            hold_instr_d = bus.imem_rdata;
            hold_pc_d    = pc_q;
            valid_d      = 1'b0;
            state_d      = S_IMM;
          end else begin
            valid_d    = 1'b1;
            instr_d    = bus.imem_rdata;
            imm_d      = '0;
            ipc_d      = pc_q;
            ipc_next_d = pc_inc;
          end
        end
        S_IMM: begin
          // current word is the immediate; it is never decoded
          pc_d       = pc_inc;
          valid_d    = 1'b1;
          instr_d    = hold_instr_q;
          imm_d      = bus.imem_rdata;
          ipc_d      = hold_pc_q;
          ipc_next_d = pc_inc;
          state_d    = S_FETCH;
        end
        default: begin
          state_d = S_FETCH;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.if_id_valid   = valid_q;
  assign bus.if_id_instr   = instr_q;
  assign bus.if_id_imm     = imm_q;
  assign bus.if_id_pc      = ipc_q;
  assign bus.if_id_pc_next = ipc_next_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(32), .INSTR_W(16)) bus();

  fetch_unit #(.PC_W(32), .INSTR_W(16), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 256-word memory aliased over the address space (0xFFFFFFFF -> 0xFF)
  logic [15:0] mem [256];
  assign bus.imem_rdata = mem[bus.imem_addr[7:0]];

  int errors = 0;
  int checks = 0;

  // reference model: architectural PC, pending opcode word, expected IF/ID
  logic [31:0] m_pc;
  bit          m_pend;
  logic [15:0] m_hold;
  logic [31:0] m_hpc;
  logic        e_valid;
  logic [15:0] e_instr, e_imm;
  logic [31:0] e_pc, e_pcn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit two_word(input logic [15:0] w);
    logic [6:0] o;
    o = w[15:9];
    return (o ==? 7'b01?1000) || (o ==? 7'b101?000);
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 0; m_hold = '0; m_hpc = '0;
    e_valid = 0; e_instr = '0; e_imm = '0; e_pc = '0; e_pcn = '0;
  endtask

  task automatic model_edge(input bit s, input bit f, input logic [31:0] t);
    logic [15:0] w;
    w = mem[m_pc[7:0]];
    if (f) begin
      m_pc = t; m_pend = 0; e_valid = 0;
    end else if (!s) begin
      if (m_pend) begin
        e_valid = 1; e_instr = m_hold; e_imm = w; e_pc = m_hpc; e_pcn = m_pc + 1;
        m_pc = m_pc + 1; m_pend = 0;
      end else if (two_word(w)) begin
        m_hold = w; m_hpc = m_pc; m_pc = m_pc + 1; m_pend = 1; e_valid = 0;
      end else begin
        e_valid = 1; e_instr = w; e_imm = 16'h0; e_pc = m_pc; e_pcn = m_pc + 1;
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_addr", bus.imem_addr, m_pc);
    check("valid", {31'b0, bus.if_id_valid}, {31'b0, e_valid});
    check("instr", {16'b0, bus.if_id_instr}, {16'b0, e_instr});
    check("imm", {16'b0, bus.if_id_imm}, {16'b0, e_imm});
    check("pc", bus.if_id_pc, e_pc);
    check("pc_next", bus.if_id_pc_next, e_pcn);
  endtask

  // called at posedge+1; applies inputs, advances one clock, compares
  task automatic tick(input bit s, input bit f, input logic [31:0] t);
    bus.stall = s; bus.flush = f; bus.branch_target = t;
    model_edge(s, f, t);
    @(posedge clk); #1;
    compare_all();
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 3))
        0: w[15:9] = 7'b0101000;
        1: w[15:9] = 7'b0111000;
        2: w[15:9] = 7'b1010000;
        default: w[15:9] = 7'b1011000;
      endcase
    end
    return w;
  endfunction

  initial begin
    bus.stall = 0; bus.flush = 0; bus.branch_target = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h2000; mem[1] = 16'h1800; mem[2] = 16'h2400; mem[3] = 16'h0000;
    mem[4] = 16'h7000; mem[5] = 16'hBEEF; mem[6] = 16'hB000; mem[7] = 16'h1234;
    mem[8'h40] = 16'h1800; mem[8'h10] = 16'h0000; mem[8'hFF] = 16'hA000;
    model_reset();

    // reset state
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;

    // three one-word ops
    tick(0, 0, 0); check("pc0", bus.if_id_pc, 32'd0);
    tick(0, 0, 0); check("pc1", bus.if_id_pc, 32'd1);
    tick(0, 0, 0); check("pc2", bus.if_id_pc, 32'd2);
    // stall holding ADD at pc=2
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      check("stall_pc", bus.if_id_pc, 32'd2);
      check("stall_addr", bus.imem_addr, 32'd3);
    end
    tick(0, 0, 0); check("after_stall_pc", bus.if_id_pc, 32'd3);
    // LDM two-word
    tick(0, 0, 0); check("ldm_bubble", {31'b0, bus.if_id_valid}, 32'd0);
    tick(0, 0, 0);
    check("ldm_instr", {16'b0, bus.if_id_instr}, 32'h7000);
    check("ldm_imm", {16'b0, bus.if_id_imm}, 32'hBEEF);
    check("ldm_pcn", bus.if_id_pc_next, 32'd6);
    // STD opcode fetched, flushed while in S_IMM
    tick(0, 0, 0);
    tick(0, 1, 32'h40);
    check("flush_addr", bus.imem_addr, 32'h40);
    check("flush_valid", {31'b0, bus.if_id_valid}, 32'd0);
    tick(0, 0, 0); check("post_flush_pc", bus.if_id_pc, 32'h40);
    // flush and stall together
    tick(1, 1, 32'h10);
    check("fs_addr", bus.imem_addr, 32'h10);
    check("fs_valid", {31'b0, bus.if_id_valid}, 32'd0);
    // LDD straddling the PC wrap
    tick(0, 1, 32'hFFFF_FFFF);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check("wrap_pc", bus.if_id_pc, 32'hFFFF_FFFF);
    check("wrap_pcn", bus.if_id_pc_next, 32'd1);
    check("wrap_imm", {16'b0, bus.if_id_imm}, 32'h2000);
    // asynchronous reset in the middle of S_IMM
    tick(0, 1, 32'd4);
    tick(0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;

    // randomized run
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    for (int n = 0; n < 3000; n++) begin
      bit s, f;
      logic [31:0] t;
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 9) == 0);
      t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 255));
      tick(s, f, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
